window_gen_3x3: RTL and testbench

- Streaming 3x3 window generator that sits upstream of the 3x3 RGB convolution stage and drives that stage's start_conv and 27-byte window interface.
- Takes a raster-order RGB pixel stream (one pixel per accepted cycle).
- Keeps the two previous image lines in internal line buffers.
- Emits one registered 3x3 window per pixel for which a full window exists (valid-mode, no border padding).

---
 rtl/window_gen_3x3.sv | 98 +++++++++
 tb/tb_window_gen_3x3.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// 3x3 RGB window generator over a raster stream; window/start_conv registered one cycle after the pixel.
// No backpressure: every pix_valid pixel is consumed; idle cycles freeze all state.
module window_gen_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [23:0] pix_data,
    output logic        start_conv,
    output logic [7:0]  R_window00, R_window01, R_window02,
    output logic [7:0]  R_window10, R_window11, R_window12,
    output logic [7:0]  R_window20, R_window21, R_window22,
    output logic [7:0]  G_window00, G_window01, G_window02,
    output logic [7:0]  G_window10, G_window11, G_window12,
    output logic [7:0]  G_window20, G_window21, G_window22,
    output logic [7:0]  B_window00, B_window01, B_window02,
    output logic [7:0]  B_window10, B_window11, B_window12,
    output logic [7:0]  B_window20, B_window21, B_window22,
    output logic        frame_done
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    logic [23:0]   r_lb0 [IMG_W];
    logic [23:0]   r_lb1 [IMG_W];
    logic [23:0]   r_win [3][3];
    logic [CW-1:0] r_col, r_row;

    logic [CW-1:0] w_col, w_row, w_col_nxt, w_row_nxt;
    logic [AW-1:0] w_idx;
    logic [23:0]   w_up1, w_up2;
    logic          w_last;

    // sof overrides the counters so a mid-frame restart takes effect on this very pixel
    always_comb begin
        w_col     = pix_sof ? '0 : r_col;
        w_row     = pix_sof ? '0 : r_row;
        w_idx     = w_col[AW-1:0];
        w_up1     = r_lb0[w_idx];
        w_up2     = r_lb1[w_idx];
        w_last    = (w_row == ROW_LAST) && (w_col == COL_LAST);
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb1[w_idx] <= w_up1;
            r_lb0[w_idx] <= pix_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            start_conv <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_win[i][j] <= '0;
        end else begin
            start_conv <= pix_valid && (w_row >= TWO) && (w_col >= TWO);
            frame_done <= pix_valid && w_last;
            if (pix_valid) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_up2;
                r_win[1][2] <= w_up1;
                r_win[2][2] <= pix_data;
            end
        end
    end

    assign R_window00 = r_win[0][0][23:16]; assign R_window01 = r_win[0][1][23:16]; assign R_window02 = r_win[0][2][23:16];
    assign R_window10 = r_win[1][0][23:16]; assign R_window11 = r_win[1][1][23:16]; assign R_window12 = r_win[1][2][23:16];
    assign R_window20 = r_win[2][0][23:16]; assign R_window21 = r_win[2][1][23:16]; assign R_window22 = r_win[2][2][23:16];
    assign G_window00 = r_win[0][0][15:8];  assign G_window01 = r_win[0][1][15:8];  assign G_window02 = r_win[0][2][15:8];
    assign G_window10 = r_win[1][0][15:8];  assign G_window11 = r_win[1][1][15:8];  assign G_window12 = r_win[1][2][15:8];
    assign G_window20 = r_win[2][0][15:8];  assign G_window21 = r_win[2][1][15:8];  assign G_window22 = r_win[2][2][15:8];
    assign B_window00 = r_win[0][0][7:0];   assign B_window01 = r_win[0][1][7:0];   assign B_window02 = r_win[0][2][7:0];
    assign B_window10 = r_win[1][0][7:0];   assign B_window11 = r_win[1][1][7:0];   assign B_window12 = r_win[1][2][7:0];
    assign B_window20 = r_win[2][0][7:0];   assign B_window21 = r_win[2][1][7:0];   assign B_window22 = r_win[2][2][7:0];
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 4x4 instance and a 5x3 instance share one stimulus stream, sel picks the one checked.
module tb_window_gen_3x3;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [23:0] pix_data = '0;

    logic       st_a, fd_a, st_b, fd_b;
    logic [7:0] ra [9], ga [9], ba [9];
    logic [7:0] rb [9], gb [9], bb [9];

    always #5 clk = ~clk;

    window_gen_3x3 #(.IMG_W(4), .IMG_H(4), .CW(10)) dut_a (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .start_conv(st_a), .frame_done(fd_a),
        .R_window00(ra[0]), .R_window01(ra[1]), .R_window02(ra[2]),
        .R_window10(ra[3]), .R_window11(ra[4]), .R_window12(ra[5]),
        .R_window20(ra[6]), .R_window21(ra[7]), .R_window22(ra[8]),
        .G_window00(ga[0]), .G_window01(ga[1]), .G_window02(ga[2]),
        .G_window10(ga[3]), .G_window11(ga[4]), .G_window12(ga[5]),
        .G_window20(ga[6]), .G_window21(ga[7]), .G_window22(ga[8]),
        .B_window00(ba[0]), .B_window01(ba[1]), .B_window02(ba[2]),
        .B_window10(ba[3]), .B_window11(ba[4]), .B_window12(ba[5]),
        .B_window20(ba[6]), .B_window21(ba[7]), .B_window22(ba[8]));

    window_gen_3x3 #(.IMG_W(5), .IMG_H(3), .CW(10)) dut_b (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .start_conv(st_b), .frame_done(fd_b),
        .R_window00(rb[0]), .R_window01(rb[1]), .R_window02(rb[2]),
        .R_window10(rb[3]), .R_window11(rb[4]), .R_window12(rb[5]),
        .R_window20(rb[6]), .R_window21(rb[7]), .R_window22(rb[8]),
        .G_window00(gb[0]), .G_window01(gb[1]), .G_window02(gb[2]),
        .G_window10(gb[3]), .G_window11(gb[4]), .G_window12(gb[5]),
        .G_window20(gb[6]), .G_window21(gb[7]), .G_window22(gb[8]),
        .B_window00(bb[0]), .B_window01(bb[1]), .B_window02(bb[2]),
        .B_window10(bb[3]), .B_window11(bb[4]), .B_window12(bb[5]),
        .B_window20(bb[6]), .B_window21(bb[7]), .B_window22(bb[8]));

    int n_vec = 0;
    int n_err = 0;
    int sel   = 0;
    int mw    = 4;
    int mh    = 4;

    // reference model: image indexed by frame position, window = 3x3 neighbourhood ending at the pixel
    logic [23:0] img [8][8];
    logic [23:0] exp_win [3][3];
    int  m_row, m_col;
    bit  exp_start, exp_done, win_known;
    int  cnt_start, cnt_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] obs_win(input int k);
        if (sel == 0) return {ra[k], ga[k], ba[k]};
        return {rb[k], gb[k], bb[k]};
    endfunction

    task automatic model_reset();
        m_row = 0; m_col = 0;
        exp_start = 0; exp_done = 0; win_known = 1;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                exp_win[i][j] = '0;
    endtask

    task automatic compare_outputs();
        logic st, fd;
        st = (sel == 0) ? st_a : st_b;
        fd = (sel == 0) ? fd_a : fd_b;
        chk("start_conv", 32'(st), 32'(exp_start));
        chk("frame_done", 32'(fd), 32'(exp_done));
        if (win_known)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    chk($sformatf("window%0d%0d", i, j), 32'(obs_win(i*3+j)), 32'(exp_win[i][j]));
        if (st) cnt_start++;
        if (fd) cnt_done++;
    endtask

    task automatic step(input bit v, input bit sof, input logic [23:0] d);
        int r, c;
        @(negedge clk);
        pix_valid = v; pix_sof = sof; pix_data = d;
        @(posedge clk);
        exp_start = 0; exp_done = 0;
        if (v) begin
            r = sof ? 0 : m_row;
            c = sof ? 0 : m_col;
            img[r][c] = d;
            exp_start = (r >= 2) && (c >= 2);
            exp_done  = (r == mh-1) && (c == mw-1);
            win_known = exp_start;
            if (exp_start)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_win[i][j] = img[r-2+i][c-2+j];
            if (c == mw-1) begin
                m_col = 0;
                m_row = (r == mh-1) ? 0 : r + 1;
            end else begin
                m_col = c + 1;
                m_row = r;
            end
        end
        #1;
        compare_outputs();
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // pixel (r,c): R = 16r+c+off, G = R+0x40, B = R+0x80; gap 0 none, 1 two idles, 2 random idles
    task automatic frame(input int off, input bit sof, input int gap, input int npix);
        logic [7:0] rv;
        for (int p = 0; p < npix; p++) begin
            rv = 8'(16 * (p / mw) + (p % mw) + off);
            step(1'b1, sof && (p == 0), {rv, rv + 8'h40, rv + 8'h80});
            if (gap == 1) begin
                step(1'b0, 1'b0, 24'hdead00);
                step(1'b0, 1'b0, 24'hbeef00);
            end else if (gap == 2) begin
                repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 24'($urandom));
            end
        end
    endtask

    initial begin
        model_reset();
        do_reset(2);

        cnt_start = 0; cnt_done = 0;
        frame(0, 1, 0, 16);
        step(0, 0, 24'h0);
        chk("pulses_plain", cnt_start, 4);
        chk("done_plain", cnt_done, 1);

        cnt_start = 0; cnt_done = 0;
        frame(0, 1, 1, 16);
        chk("pulses_gapped", cnt_start, 4);
        chk("done_gapped", cnt_done, 1);

        frame(0, 1, 0, 16);
        cnt_start = 0; cnt_done = 0;
        frame(5, 0, 0, 16);
        chk("pulses_nosof", cnt_start, 4);
        chk("done_nosof", cnt_done, 1);

        cnt_start = 0; cnt_done = 0;
        frame(0, 1, 0, 9);
        frame(5, 1, 0, 16);
        chk("pulses_midsof", cnt_start, 4);

        frame(0, 1, 2, 12);
        do_reset(2);
        cnt_start = 0; cnt_done = 0;
        frame(0, 1, 0, 16);
        chk("pulses_after_rst", cnt_start, 4);
        chk("done_after_rst", cnt_done, 1);

        sel = 1; mw = 5; mh = 3;
        do_reset(2);
        cnt_start = 0; cnt_done = 0;
        frame(0, 1, 0, 15);
        step(0, 0, 24'h0);
        chk("pulses_5x3", cnt_start, 3);
        chk("done_5x3", cnt_done, 1);

        sel = 0; mw = 4; mh = 4;
        do_reset(1);
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 24'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
